// File: rtl/ysyx_25020047_pkg.sv
// Shared writeback-stage types: source/load encodings and the buffered commit entry.
package ysyx_25020047_pkg;

    localparam int ENTRY_XLEN = 64;
    localparam int ENTRY_RAW  = 5;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LINK = 2'd1,
        WB_LOAD = 2'd2,
        WB_NONE = 2'd3
    } wb_sel_e;

    typedef enum logic [2:0] {
        LD_LB  = 3'd0,
        LD_LH  = 3'd1,
        LD_LW  = 3'd2,
        LD_LD  = 3'd3,
        LD_LBU = 3'd4,
        LD_LHU = 3'd5
    } ld_type_e;

    // Entry is sized for the widest datapath; narrower builds zero-extend on push.
    typedef struct packed {
        logic                  wen;
        logic                  misalign;
        logic [ENTRY_RAW-1:0]  rd;
        logic [ENTRY_XLEN-1:0] wdata;
        logic [ENTRY_XLEN-1:0] dnpc;
        logic [ENTRY_XLEN-1:0] pc;
    } wbu_entry_t;

    function automatic logic wen_allowed(input logic [1:0] wb_sel, input logic rd_nz,
                                         input logic misalign);
        return (wb_sel != WB_NONE) && rd_nz && !misalign;
    endfunction

endpackage

// File: rtl/ysyx_25020047_ld_align.sv
// Combinational load extraction: picks byte/half/word/dword at addr_lo and extends it.
module ysyx_25020047_ld_align
    import ysyx_25020047_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] memdata,
    input  logic [2:0]      addr_lo,
    input  logic [2:0]      ld_type,
    output logic [XLEN-1:0] data,
    output logic            misalign
);

    logic [XLEN-1:0] shifted;

    // Offsets past the word simply shift everything out; those cases are misaligned anyway.
    assign shifted = memdata >> {addr_lo, 3'b000};

    always_comb begin
        data = shifted;
        case (ld_type)
            LD_LB:   data = XLEN'($signed(shifted[7:0]));
            LD_LBU:  data = XLEN'(shifted[7:0]);
            LD_LH:   data = XLEN'($signed(shifted[15:0]));
            LD_LHU:  data = XLEN'(shifted[15:0]);
            LD_LW:   data = XLEN'($signed(shifted[31:0]));
            default: data = shifted;
        endcase
    end

    always_comb begin
        misalign = 1'b0;
        case (ld_type)
            LD_LH, LD_LHU: misalign = addr_lo[0];
            LD_LW:         misalign = |addr_lo[1:0];
            LD_LD:         misalign = |addr_lo;
            default:       misalign = 1'b0;
        endcase
    end

endmodule

// File: rtl/ysyx_25020047_wbu_pipe.sv
// Writeback stage: computes the commit payload on push and buffers it in a small FIFO.
// Optional retired-instruction counter enabled by YSYX_25020047_WBU_MINSTRET_EN.
module ysyx_25020047_wbu_pipe
    import ysyx_25020047_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NR_REG = 32,
    parameter int DEPTH  = 2,
    localparam int RAW   = $clog2(NR_REG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_wb_sel,
    input  logic [2:0]      in_ld_type,
    input  logic            in_jump,
    input  logic [XLEN-1:0] in_result,
    input  logic [XLEN-1:0] in_memdata,
    input  logic [XLEN-1:0] in_snpc,
    input  logic [XLEN-1:0] in_pc,
    input  logic [RAW-1:0]  in_rd,
    input  logic [2:0]      in_addr_lo,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            rf_wen,
    output logic [RAW-1:0]  rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [XLEN-1:0] dnpc,
    output logic [XLEN-1:0] commit_pc,
    output logic            misalign
`ifdef YSYX_25020047_WBU_MINSTRET_EN
    ,
    output logic [63:0]     minstret
`endif
);

    localparam int PW = $clog2(DEPTH);

    logic [XLEN-1:0] ld_data;
    logic            ld_misalign;
    logic            mis_push;
    logic [XLEN-1:0] wdata_push;
    logic [XLEN-1:0] dnpc_push;
    wbu_entry_t      entry_push;

    ysyx_25020047_ld_align #(
        .XLEN(XLEN)
    ) u_ld_align (
        .memdata (in_memdata),
        .addr_lo (in_addr_lo),
        .ld_type (in_ld_type),
        .data    (ld_data),
        .misalign(ld_misalign)
    );

    assign mis_push  = (in_wb_sel == WB_LOAD) && ld_misalign;
    assign dnpc_push = in_jump ? {in_result[XLEN-1:1], 1'b0} : in_snpc;

    always_comb begin
        wdata_push = '0;
        case (in_wb_sel)
            WB_ALU:  wdata_push = in_result;
            WB_LINK: wdata_push = in_snpc;
            WB_LOAD: wdata_push = ld_data;
            default: wdata_push = '0;
        endcase
    end

    always_comb begin
        entry_push.wen      = wen_allowed(in_wb_sel, |in_rd, mis_push);
        entry_push.misalign = mis_push;
        entry_push.rd       = ENTRY_RAW'(in_rd);
        entry_push.wdata    = ENTRY_XLEN'(wdata_push);
        entry_push.dnpc     = ENTRY_XLEN'(dnpc_push);
        entry_push.pc       = ENTRY_XLEN'(in_pc);
    end

    wbu_entry_t    mem_reg [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW:0]   count_reg;
    wbu_entry_t    head;
    logic          push;
    logic          pop;

    assign in_ready  = count_reg < (PW+1)'(DEPTH);
    assign out_valid = count_reg != '0;
    // Flush wins over any handshake in the same cycle.
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;
    assign head      = mem_reg[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= entry_push;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally at PW bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (PW+1)'(1);
                2'b01:   count_reg <= count_reg - (PW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Payload reads as zero whenever nothing is buffered, including straight out of reset.
    assign rf_wen    = out_valid && head.wen;
    assign misalign  = out_valid && head.misalign;
    assign rf_waddr  = out_valid ? head.rd[RAW-1:0] : '0;
    assign rf_wdata  = out_valid ? head.wdata[XLEN-1:0] : '0;
    assign dnpc      = out_valid ? head.dnpc[XLEN-1:0] : '0;
    assign commit_pc = out_valid ? head.pc[XLEN-1:0] : '0;

    generate
        if (XLEN < ENTRY_XLEN) begin : g_xpad
            logic unused_xhi;
            assign unused_xhi = ^{head.wdata[ENTRY_XLEN-1:XLEN], head.dnpc[ENTRY_XLEN-1:XLEN],
                                  head.pc[ENTRY_XLEN-1:XLEN]};
        end
        if (RAW < ENTRY_RAW) begin : g_rpad
            logic unused_rhi;
            assign unused_rhi = ^head.rd[ENTRY_RAW-1:RAW];
        end
    endgenerate

`ifdef YSYX_25020047_WBU_MINSTRET_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            minstret <= '0;
        end else if (pop && !head.misalign) begin
            minstret <= minstret + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_25020047_wbu_pipe.sv
// Bench for the writeback pipe: directed vector table, corner sequences and a randomized queue model.
module tb_ysyx_25020047_wbu_pipe;
    import ysyx_25020047_pkg::*;

    localparam int XLEN   = 32;
    localparam int NR_REG = 32;
    localparam int DEPTH  = 2;
    localparam int RAW    = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [1:0]      in_wb_sel = 2'd0;
    logic [2:0]      in_ld_type = 3'd0;
    logic            in_jump = 1'b0;
    logic [XLEN-1:0] in_result = '0;
    logic [XLEN-1:0] in_memdata = '0;
    logic [XLEN-1:0] in_snpc = '0;
    logic [XLEN-1:0] in_pc = '0;
    logic [RAW-1:0]  in_rd = '0;
    logic [2:0]      in_addr_lo = '0;
    logic            flush = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            rf_wen;
    logic [RAW-1:0]  rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic [XLEN-1:0] dnpc;
    logic [XLEN-1:0] commit_pc;
    logic            misalign;
`ifdef YSYX_25020047_WBU_MINSTRET_EN
    logic [63:0]     minstret;
`endif

    ysyx_25020047_wbu_pipe #(.XLEN(XLEN), .NR_REG(NR_REG), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_wb_sel(in_wb_sel), .in_ld_type(in_ld_type), .in_jump(in_jump),
        .in_result(in_result), .in_memdata(in_memdata), .in_snpc(in_snpc), .in_pc(in_pc),
        .in_rd(in_rd), .in_addr_lo(in_addr_lo), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .dnpc(dnpc), .commit_pc(commit_pc), .misalign(misalign)
`ifdef YSYX_25020047_WBU_MINSTRET_EN
        , .minstret(minstret)
`endif
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    longint unsigned exp_minstret = 0;

    typedef struct {
        logic [1:0]  sel;
        logic [2:0]  lt;
        logic        jump;
        logic [31:0] result;
        logic [31:0] memdata;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [2:0]  lo;
        logic        e_wen;
        logic [31:0] e_wdata;
        logic [31:0] e_dnpc;
        logic        e_mis;
        logic        chk_wd;
    } vec_t;

    typedef struct {
        logic        wen;
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic [31:0] dnpc;
        logic [31:0] pc;
        logic        mis;
    } exp_t;

    vec_t vecs[11];
    exp_t q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] sel, input logic [2:0] lt, input logic j,
                         input logic [31:0] res, input logic [31:0] mem, input logic [31:0] pc,
                         input logic [4:0] rd, input logic [2:0] lo);
        in_valid   = v;
        in_wb_sel  = sel;
        in_ld_type = lt;
        in_jump    = j;
        in_result  = res;
        in_memdata = mem;
        in_pc      = pc;
        in_snpc    = pc + 32'd4;
        in_rd      = rd;
        in_addr_lo = lo;
    endtask

    function automatic vec_t mk(input logic [1:0] sel, input logic [2:0] lt, input logic j,
                                input logic [31:0] res, input logic [31:0] mem, input logic [31:0] pc,
                                input logic [4:0] rd, input logic [2:0] lo, input logic e_wen,
                                input logic [31:0] e_wdata, input logic [31:0] e_dnpc,
                                input logic e_mis, input logic chk_wd);
        vec_t v;
        v.sel = sel; v.lt = lt; v.jump = j; v.result = res; v.memdata = mem; v.pc = pc;
        v.rd = rd; v.lo = lo; v.e_wen = e_wen; v.e_wdata = e_wdata; v.e_dnpc = e_dnpc;
        v.e_mis = e_mis; v.chk_wd = chk_wd;
        return v;
    endfunction

    // Reference model: plain arithmetic on the architectural load/writeback rules.
    function automatic exp_t ref_entry(input logic [1:0] sel, input logic [2:0] lt, input logic j,
                                       input logic [31:0] res, input logic [31:0] mem,
                                       input logic [31:0] pc, input logic [4:0] rd,
                                       input logic [2:0] lo);
        exp_t e;
        logic [31:0] sh;
        logic [31:0] part;
        logic [31:0] w;
        int off;
        off  = int'(lo);
        sh   = mem >> (8 * off);
        w    = sh;
        e.mis = 1'b0;
        if (lt == LD_LB || lt == LD_LBU) begin
            part = sh % 256;
            w = (lt == LD_LB && part >= 128) ? part - 32'd256 : part;
        end else if (lt == LD_LH || lt == LD_LHU) begin
            part = sh % 65536;
            w = (lt == LD_LH && part >= 32768) ? part - 32'd65536 : part;
            if (sel == WB_LOAD) e.mis = (off % 2) != 0;
        end else if (lt == LD_LW) begin
            if (sel == WB_LOAD) e.mis = (off % 4) != 0;
        end
        case (sel)
            WB_ALU:  e.wdata = res;
            WB_LINK: e.wdata = pc + 32'd4;
            WB_LOAD: e.wdata = w;
            default: e.wdata = 32'd0;
        endcase
        e.dnpc = j ? (res & 32'hFFFF_FFFE) : pc + 32'd4;
        e.pc   = pc;
        e.rd   = rd;
        e.wen  = (sel != WB_NONE) && (rd != 0) && !e.mis;
        return e;
    endfunction

    initial begin
        logic [2:0]  lt_tab[5];
        logic        r_v, r_rdy, r_fl, r_j;
        logic [1:0]  r_sel;
        logic [2:0]  r_lt, r_lo;
        logic [4:0]  r_rd;
        logic [31:0] r_res, r_mem, r_pc;
        exp_t        e_new;
        logic        do_pop, do_push;

        lt_tab[0] = LD_LB; lt_tab[1] = LD_LBU; lt_tab[2] = LD_LH;
        lt_tab[3] = LD_LHU; lt_tab[4] = LD_LW;

        vecs[0]  = mk(WB_ALU,  LD_LW,  0, 32'h0000_1234, 32'h0,          32'h8000_0000, 5'd5,  3'd0, 1, 32'h0000_1234, 32'h8000_0004, 0, 1);
        vecs[1]  = mk(WB_LOAD, LD_LB,  0, 32'h0,         32'h80FF_7F01, 32'h8000_0004, 5'd6,  3'd3, 1, 32'hFFFF_FF80, 32'h8000_0008, 0, 1);
        vecs[2]  = mk(WB_LOAD, LD_LBU, 0, 32'h0,         32'h80FF_7F01, 32'h8000_0008, 5'd6,  3'd3, 1, 32'h0000_0080, 32'h8000_000C, 0, 1);
        vecs[3]  = mk(WB_LOAD, LD_LHU, 0, 32'h0,         32'h80FF_7F01, 32'h8000_000C, 5'd7,  3'd2, 1, 32'h0000_80FF, 32'h8000_0010, 0, 1);
        vecs[4]  = mk(WB_LOAD, LD_LH,  0, 32'h0,         32'h80FF_7F01, 32'h8000_0010, 5'd7,  3'd2, 1, 32'hFFFF_80FF, 32'h8000_0014, 0, 1);
        vecs[5]  = mk(WB_LOAD, LD_LW,  0, 32'h0,         32'h80FF_7F01, 32'h8000_0014, 5'd8,  3'd2, 0, 32'h0,         32'h8000_0018, 1, 0);
        vecs[6]  = mk(WB_LINK, LD_LW,  1, 32'h8000_0103, 32'h0,          32'h8000_0010, 5'd1,  3'd0, 1, 32'h8000_0014, 32'h8000_0102, 0, 1);
        vecs[7]  = mk(WB_ALU,  LD_LW,  0, 32'h0000_DEAD, 32'h0,          32'h8000_0020, 5'd0,  3'd0, 0, 32'h0000_DEAD, 32'h8000_0024, 0, 1);
        vecs[8]  = mk(WB_NONE, LD_LW,  0, 32'h0000_BEEF, 32'h0,          32'h8000_0024, 5'd3,  3'd0, 0, 32'h0,         32'h8000_0028, 0, 1);
        vecs[9]  = mk(WB_LOAD, LD_LW,  0, 32'h0,         32'h1234_5678, 32'h8000_0028, 5'd9,  3'd0, 1, 32'h1234_5678, 32'h8000_002C, 0, 1);
        vecs[10] = mk(WB_LOAD, LD_LBU, 0, 32'h0,         32'h80FF_7F01, 32'h8000_002C, 5'd10, 3'd1, 1, 32'h0000_007F, 32'h8000_0030, 0, 1);

        // Reset state, checked before any clock edge so only the asynchronous path can clear it.
        rst_n = 1'b0;
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_rf_wen", rf_wen, 0);
        check("rst_rf_wdata", rf_wdata, 0);
        check("rst_dnpc", dnpc, 0);
        check("rst_commit_pc", commit_pc, 0);
        check("rst_misalign", misalign, 0);
`ifdef YSYX_25020047_WBU_MINSTRET_EN
        check("rst_minstret", minstret, 0);
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", in_ready, 1);

        // Directed vector table: one push, one-cycle latency, immediate pop.
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            drive(1, vecs[i].sel, vecs[i].lt, vecs[i].jump, vecs[i].result, vecs[i].memdata,
                  vecs[i].pc, vecs[i].rd, vecs[i].lo);
            @(posedge clk); #1;
            in_valid = 1'b0;
            $display("vec %0d: out_valid=%0d wen=%0d waddr=%0d wdata=0x%08h dnpc=0x%08h mis=%0d",
                     i, out_valid, rf_wen, rf_waddr, rf_wdata, dnpc, misalign);
            check($sformatf("vec%0d_out_valid", i), out_valid, 1);
            check($sformatf("vec%0d_rf_wen", i), rf_wen, vecs[i].e_wen);
            check($sformatf("vec%0d_rf_waddr", i), rf_waddr, vecs[i].rd);
            if (vecs[i].chk_wd) check($sformatf("vec%0d_rf_wdata", i), rf_wdata, vecs[i].e_wdata);
            check($sformatf("vec%0d_dnpc", i), dnpc, vecs[i].e_dnpc);
            check($sformatf("vec%0d_commit_pc", i), commit_pc, vecs[i].pc);
            check($sformatf("vec%0d_misalign", i), misalign, vecs[i].e_mis);
            if (!vecs[i].e_mis) exp_minstret++;
            @(posedge clk); #1;
            check($sformatf("vec%0d_drained", i), out_valid, 0);
`ifdef YSYX_25020047_WBU_MINSTRET_EN
            check($sformatf("vec%0d_minstret", i), minstret, exp_minstret);
`endif
        end

        // Backpressure: fill to DEPTH, third push refused, head held, then in-order drain.
        out_ready = 1'b0;
        drive(1, WB_ALU, LD_LW, 0, 32'h0000_000A, 0, 32'h8000_1000, 5'd10, 0);
        @(posedge clk); #1;
        check("bp_in_ready_one", in_ready, 1);
        drive(1, WB_ALU, LD_LW, 0, 32'h0000_000B, 0, 32'h8000_1004, 5'd11, 0);
        @(posedge clk); #1;
        check("bp_in_ready_full", in_ready, 0);
        drive(1, WB_ALU, LD_LW, 0, 32'h0000_000C, 0, 32'h8000_1008, 5'd12, 0);
        repeat (2) @(posedge clk); #1;
        $display("bp hold: wdata=0x%08h waddr=%0d", rf_wdata, rf_waddr);
        check("bp_hold_valid", out_valid, 1);
        check("bp_hold_wdata", rf_wdata, 32'h0000_000A);
        check("bp_hold_waddr", rf_waddr, 10);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        $display("bp drain: wdata=0x%08h waddr=%0d", rf_wdata, rf_waddr);
        check("bp_drain_second", rf_wdata, 32'h0000_000B);
        check("bp_drain_pc", commit_pc, 32'h8000_1004);
        @(posedge clk); #1;
        check("bp_drain_empty", out_valid, 0);
        exp_minstret += 2;

        // Flush with a full buffer, concurrent push and pop all discarded.
        out_ready = 1'b0;
        drive(1, WB_ALU, LD_LW, 0, 32'h0000_00D0, 0, 32'h8000_2000, 5'd13, 0);
        @(posedge clk); #1;
        drive(1, WB_ALU, LD_LW, 0, 32'h0000_00E0, 0, 32'h8000_2004, 5'd14, 0);
        @(posedge clk); #1;
        check("fl_full", in_ready, 0);
        drive(1, WB_ALU, LD_LW, 0, 32'h0000_00F0, 0, 32'h8000_2008, 5'd15, 0);
        flush     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        $display("flush: out_valid=%0d in_ready=%0d", out_valid, in_ready);
        check("fl_out_valid", out_valid, 0);
        check("fl_in_ready", in_ready, 1);
        @(posedge clk); #1;
        check("fl_no_ghost", out_valid, 0);
`ifdef YSYX_25020047_WBU_MINSTRET_EN
        check("fl_minstret", minstret, exp_minstret);
`endif
        drive(1, WB_ALU, LD_LW, 0, 32'h0000_0055, 0, 32'h8000_3000, 5'd0, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("rd0_valid", out_valid, 1);
        check("rd0_wen", rf_wen, 0);
        exp_minstret++;
        @(posedge clk); #1;

        // Randomized traffic against the queue model.
        for (int c = 0; c < 400; c++) begin
            check("rnd_out_valid", out_valid, q.size() != 0);
            check("rnd_in_ready", in_ready, q.size() < DEPTH);
            if (q.size() != 0) begin
                check("rnd_rf_wen", rf_wen, q[0].wen);
                check("rnd_rf_waddr", rf_waddr, q[0].rd);
                check("rnd_rf_wdata", rf_wdata, q[0].wdata);
                check("rnd_dnpc", dnpc, q[0].dnpc);
                check("rnd_commit_pc", commit_pc, q[0].pc);
                check("rnd_misalign", misalign, q[0].mis);
            end
            r_v   = $urandom_range(0, 3) != 0;
            r_rdy = $urandom_range(0, 2) != 0;
            r_fl  = $urandom_range(0, 31) == 0;
            r_sel = 2'($urandom_range(0, 3));
            r_lt  = lt_tab[$urandom_range(0, 4)];
            r_lo  = 3'($urandom_range(0, 3));
            r_rd  = 5'($urandom_range(0, 31));
            r_j   = 1'($urandom_range(0, 1));
            r_res = $urandom;
            r_mem = $urandom;
            r_pc  = $urandom & 32'hFFFF_FFFC;
            drive(r_v, r_sel, r_lt, r_j, r_res, r_mem, r_pc, r_rd, r_lo);
            out_ready = r_rdy;
            flush     = r_fl;
            e_new = ref_entry(r_sel, r_lt, r_j, r_res, r_mem, r_pc, r_rd, r_lo);
            do_pop  = (q.size() != 0) && r_rdy;
            do_push = r_v && (q.size() < DEPTH);
            @(posedge clk); #1;
            if (r_fl) begin
                q.delete();
            end else begin
                if (do_pop) begin
                    $display("rnd commit: pc=0x%08h rd=%0d wdata=0x%08h wen=%0d mis=%0d",
                             q[0].pc, q[0].rd, q[0].wdata, q[0].wen, q[0].mis);
                    if (!q[0].mis) exp_minstret++;
                    void'(q.pop_front());
                end
                if (do_push) q.push_back(e_new);
            end
        end
        in_valid = 1'b0;
        flush    = 1'b0;
`ifdef YSYX_25020047_WBU_MINSTRET_EN
        check("rnd_minstret", minstret, exp_minstret);
`endif

        // Reset mid-operation drops buffered entries without waiting for a clock edge.
        out_ready = 1'b0;
        drive(1, WB_ALU, LD_LW, 0, 32'h0000_0077, 0, 32'h8000_4000, 5'd4, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("mid_pre_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        $display("mid reset: out_valid=%0d in_ready=%0d", out_valid, in_ready);
        check("mid_out_valid", out_valid, 0);
        check("mid_rf_wen", rf_wen, 0);
        check("mid_rf_wdata", rf_wdata, 0);
        check("mid_in_ready", in_ready, 1);
`ifdef YSYX_25020047_WBU_MINSTRET_EN
        check("mid_minstret", minstret, 0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("mid_after_release", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_25020047_wbu_pipe.md
YSYX_25020047_WBU_PIPE -- requirements
Module: ysyx_25020047_wbu_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width (32 or 64).
REQ-002 SHALL have parameter NR_REG, default 32, GPR count (16 or 32); RAW = log2(NR_REG).
REQ-003 SHALL have parameter DEPTH, default 2, buffer entries (power of two, >=2).
REQ-004 SHALL have port clk  in  1  clock, all state on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port in_valid/in_ready  in/out  1/1  upstream (MEM) handshake.
REQ-007 SHALL have port in_wb_sel  in  2  writeback source: ALU, LINK, LOAD, NONE.
REQ-008 SHALL have port in_ld_type  in  3  LB, LBU, LH, LHU, LW (LD when XLEN=64).
REQ-009 SHALL have port in_jump  in  1  redirect: dnpc = in_result.
REQ-010 SHALL have ports in_result/in_memdata/in_snpc/in_pc  in  XLEN  ALU result, raw aligned memory word, pc+4, pc.
REQ-011 SHALL have ports in_rd  in  RAW  and  in_addr_lo  in  3  destination register, load byte offset.
REQ-012 SHALL have port flush  in  1  discard all buffered entries.
REQ-013 SHALL have port out_valid/out_ready  out/in  1/1  commit handshake.
REQ-014 SHALL have ports rf_wen out 1, rf_waddr out RAW, rf_wdata out XLEN, dnpc out XLEN, commit_pc out XLEN, misalign out 1  commit payload.

Function
REQ-015 SHALL compute wdata on push: ALU -> in_result; LINK -> in_snpc; LOAD -> extracted byte/half/word at in_addr_lo, sign- (LB/LH/LW on XLEN=64) or zero-extended (LBU/LHU); NONE -> 0.
REQ-016 SHALL compute dnpc = in_jump ? {in_result[XLEN-1:1],1'b0} : in_snpc.
REQ-017 SHALL set misalign for LH/LHU with addr_lo[0]=1, LW with addr_lo[1:0]!=0, LD with addr_lo!=0; misaligned entry commits with rf_wen=0.
REQ-018 SHALL force rf_wen=0 when rd==0 or wb_sel==NONE.
REQ-019 SHALL store computed payload in a DEPTH-entry FIFO; in_ready = (count<DEPTH), independent of in_valid.
REQ-020 SHALL present head entry registered: out_valid=(count!=0); minimum latency push->out_valid one cycle.
REQ-021 SHALL pop when out_valid&&out_ready; push and pop in same cycle when not full leaves count unchanged.
REQ-022 SHALL hold payload stable while out_valid&&!out_ready.
REQ-023 SHALL wrap read/write pointers modulo DEPTH.
REQ-024 SHALL on flush clear count and pointers next edge; flush overrides simultaneous push and pop.
REQ-025 SHALL drive rf_wen only qualified by out_valid (rf_wen=0 when out_valid=0).

Reset
REQ-026 SHALL on rst_n=0 immediately clear count, pointers, out_valid, rf_wen, misalign, rf_waddr, rf_wdata, dnpc, commit_pc to 0.
REQ-027 SHALL drop entries in flight on reset mid-operation; in_ready=1 after reset release.

Configuration
REQ-028 SHALL with YSYX_25020047_WBU_MINSTRET_EN defined add output minstret (64 bits), incremented on each pop of a non-misaligned entry, wrapping at 2^64-1 -> 0, reset 0, not cleared by flush.
REQ-029 SHALL without YSYX_25020047_WBU_MINSTRET_EN have no minstret port and no counter logic.

Structure
REQ-030 SHALL place wb_sel and ld_type encodings and the FIFO entry struct in shared package ysyx_25020047_pkg.
REQ-031 SHALL implement load extraction as sub-module ysyx_25020047_ld_align (combinational, XLEN-parametrised).

Verification
REQ-032 SHALL cover: ALU push rd=5 result=0x1234, out_ready=1 -> next cycle out_valid=1, rf_wen=1, rf_waddr=5, rf_wdata=0x1234, dnpc=snpc.
REQ-033 SHALL cover: LB memdata=0x80FF7F01 addr_lo=3 -> wdata=0xFFFFFF80; LBU same -> 0x00000080; LHU addr_lo=2 -> 0x000080FF.
REQ-034 SHALL cover: LW addr_lo=2 -> misalign=1, rf_wen=0, minstret unchanged (macro on).
REQ-035 SHALL cover: jalr in_jump=1 result=0x80000103 snpc=0x80000014 rd=1 -> dnpc=0x80000102, rf_wdata=0x80000014.
REQ-036 SHALL cover: out_ready=0, three pushes (DEPTH=2) -> in_ready=0 after second; payload held; out_ready=1 -> drained in order.
REQ-037 SHALL cover: flush with count=2 and in_valid=1 same cycle -> next cycle out_valid=0, count=0; rd=0 push -> rf_wen=0.
